case_9_sdiv_7s_4s_7_seq: RTL and testbench
==========================================

Name: case_9_sdiv_7s_4s_7_seq

Overview:
Sequential signed divider, the inverse of the 4s x 3s -> 7 multiplier. It takes a 7-bit signed product-width dividend and a 4-bit signed divisor and recovers the quotient and remainder. Radix-2 restoring division on magnitudes, one quotient bit per cycle, with a start/done handshake. Instantiated by the HLS datapath wherever a sdiv/srem of these widths is scheduled as a multi-cycle operation.

Parameters:
ID, 1, instance identifier; no functional effect.
din0_WIDTH, 7, dividend width (signed).
din1_WIDTH, 4, divisor width (signed).
dout_WIDTH, 7, quotient width; must equal din0_WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
ce  input  1  clock enable; when low, all state holds (reset still acts).
start  input  1  request; sampled only in IDLE with ce=1.
din0  input  din0_WIDTH  dividend, two's complement.
din1  input  din1_WIDTH  divisor, two's complement.
done  output  1  one-cycle pulse; quotient/remainder valid.
dout  output  dout_WIDTH  quotient, truncated toward zero.
rem  output  din1_WIDTH  remainder; sign follows dividend.

Behaviour:
- Reset: state=IDLE, done=0, dout=0, rem=0, counter=0. Reset dominates ce and start.
- FSM: IDLE -> CALC on ce&start (operands latched, signs recorded, magnitudes formed in din0_WIDTH/din1_WIDTH unsigned bits; |-64|=64, |-8|=8). CALC runs din0_WIDTH iterations, counter din0_WIDTH-1 downto 0. After the counter=0 iteration -> DONE. DONE -> IDLE unconditionally (when ce=1).
- Latency: start sampled at edge N; done=1 during cycle N+din0_WIDTH+1 (cycle 8 for the defaults). Exactly one done cycle per accepted start.
- start outside IDLE is ignored. There is no queueing. Operands need only be stable on the accepting edge.
- Iteration: partial remainder is din1_WIDTH+1 bits. Shift in the next dividend MSB and trial-subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set it to 0.
- Sign fix on the final iteration:
  - quotient negated if signs differ;
  - remainder negated if dividend negative.
  - Registered into dout/rem on entry to DONE.
- dout/rem hold their values until the next completion or reset. They are not cleared in IDLE.
- Divide by zero: dout=all ones (-1), rem=0. Same latency.
- Overflow (-64 / -1): magnitude quotient 64 is truncated to dout_WIDTH, giving dout=0x40 (-64) and rem=0. No trap.
- ce=0 in any state freezes state, counter, and outputs. A pending done cycle is stretched, not lost.
- Reset mid-CALC aborts: IDLE, done=0, outputs zeroed.

Optional Feature:
- Macro: CASE_9_SDIV_STATUS_EN.
- Defined: adds output status[1:0], updated together with dout.
  - bit0 = divide-by-zero.
  - bit1 = signed overflow (dividend = most-negative and divisor = -1).
  - Reset value 0.
- Undefined: port absent and no flag logic. dout/rem behaviour is identical in both builds.

Decomposition:
- Shared package case_9_sdiv_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - default width constants (7, 4, 7);
  - a localparam function for counter width, clog2(din0_WIDTH).
- One natural sub-module: case_9_sdiv_step. It is combinational and contains one restoring step: (partial remainder, next dividend bit, divisor magnitude) -> (new partial remainder, quotient bit).
- The top holds the FSM, counter, sign handling, and output registers.

Test Plan:
- Basic: start with din0=42, din1=6, ce=1. Expect done exactly 8 cycles after the start edge, dout=7, rem=0, done low on the following cycle.
- Mixed signs:
  - -43/6: dout=-7 (0x79), rem=-1 (0xF).
  - 43/-5: dout=-8 (0x78), rem=3.
  - -43/-5: dout=8, rem=-3 (0xD).
- Boundaries:
  - 17/0: dout=0x7F, rem=0, status=01 when CASE_9_SDIV_STATUS_EN is defined.
  - -64/-1: dout=0x40, rem=0, status=10.
  - -64/-8: dout=8, rem=0.
- Handshake: assert start again during CALC with different operands. It is ignored, and the first result is returned unchanged. A new start in the cycle after done is accepted.
- ce gating: drop ce for 3 cycles mid-CALC. Expect done at cycle 11 with a correct result and held outputs; ce low during DONE stretches done.
- Reset: assert reset at cycle 4 of CALC. Next cycle shows done=0, dout=0, rem=0, state IDLE; a subsequent 42/6 completes normally.

Source files
------------

// File: rtl/case_9_sdiv_pkg.sv
// Shared types and constants for the 7s/4s sequential signed divider.
package case_9_sdiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DIN0_W_DEF = 7;
   localparam int DIN1_W_DEF = 4;
   localparam int DOUT_W_DEF = 7;

   // Counter must hold din0_WIDTH-1 down to 0; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/case_9_sdiv_step.sv
// One restoring-division step on magnitudes: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it is non-negative.
module case_9_sdiv_step #(
   parameter int W = 4
) (
   input  logic [W:0]   pr_i,
   input  logic         bit_i,
   input  logic [W-1:0] dsr_i,
   output logic [W:0]   pr_o,
   output logic         q_o
);

   logic [W+1:0] shifted;
   logic [W+1:0] diff;

   always_comb begin
      shifted = {pr_i, bit_i};
      diff    = shifted - {2'b00, dsr_i};
      q_o     = ~diff[W+1];
      pr_o    = q_o ? diff[W:0] : shifted[W:0];
   end

endmodule

// File: rtl/case_9_sdiv_7s_4s_7_seq.sv
// Sequential signed divider (7-bit dividend / 4-bit divisor), one quotient bit
// per cycle. Optional status flags under `CASE_9_SDIV_STATUS_EN.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold last result
//   CALC  | one restoring step per enabled cycle, counter W-1 downto 0
//   DONE  | done pulse; result registered on entry
module case_9_sdiv_7s_4s_7_seq
   import case_9_sdiv_pkg::*;
#(
   parameter int ID         = 1,
   parameter int din0_WIDTH = DIN0_W_DEF,
   parameter int din1_WIDTH = DIN1_W_DEF,
   parameter int dout_WIDTH = DOUT_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  done,
   output logic [dout_WIDTH-1:0] dout,
   output logic [din1_WIDTH-1:0] rem
`ifdef CASE_9_SDIV_STATUS_EN
   ,
   output logic [1:0]            status
`endif
);

   localparam int CNT_W = cnt_width(din0_WIDTH);

   state_t                state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [din0_WIDTH-1:0] dvd_q;
   logic [din1_WIDTH-1:0] dsr_q;
   logic [din1_WIDTH:0]   pr_q;
   logic [din1_WIDTH:0]   pr_d;
   logic [din0_WIDTH-2:0] quo_q;
   logic [din0_WIDTH-1:0] quo_d;
   logic                  qbit;
   logic                  negq_q;
   logic                  negr_q;
   logic                  zero_q;
   logic                  done_q;
   logic [dout_WIDTH-1:0] dout_q;
   logic [dout_WIDTH-1:0] dout_d;
   logic [din1_WIDTH-1:0] rem_q;
   logic [din1_WIDTH-1:0] rem_d;
`ifdef CASE_9_SDIV_STATUS_EN
   logic                  ovf_q;
   logic [1:0]            status_q;
`endif

   case_9_sdiv_step #(.W(din1_WIDTH)) u_step (
      .pr_i  (pr_q),
      .bit_i (dvd_q[cnt_q]),
      .dsr_i (dsr_q),
      .pr_o  (pr_d),
      .q_o   (qbit)
   );

   // Sign fix applied to the last step's outputs so DONE sees the final value.
   always_comb begin
      quo_d  = {quo_q, qbit};
      dout_d = zero_q ? {dout_WIDTH{1'b1}} : (negq_q ? -quo_d : quo_d);
      rem_d  = zero_q ? '0
                      : (negr_q ? -pr_d[din1_WIDTH-1:0] : pr_d[din1_WIDTH-1:0]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         dvd_q    <= '0;
         dsr_q    <= '0;
         pr_q     <= '0;
         quo_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
         dout_q   <= '0;
         rem_q    <= '0;
`ifdef CASE_9_SDIV_STATUS_EN
         ovf_q    <= 1'b0;
         status_q <= '0;
`endif
      end else if (ce) begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  dvd_q  <= din0[din0_WIDTH-1] ? -din0 : din0;
                  dsr_q  <= din1[din1_WIDTH-1] ? -din1 : din1;
                  negq_q <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                  negr_q <= din0[din0_WIDTH-1];
                  zero_q <= (din1 == '0);
`ifdef CASE_9_SDIV_STATUS_EN
                  ovf_q  <= (din0 == {1'b1, {(din0_WIDTH-1){1'b0}}}) && (din1 == '1);
`endif
                  pr_q    <= '0;
                  quo_q   <= '0;
                  cnt_q   <= CNT_W'(din0_WIDTH - 1);
                  state_q <= CALC;
               end
            end
            CALC: begin
               pr_q  <= pr_d;
               quo_q <= quo_d[din0_WIDTH-2:0];
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  dout_q   <= dout_d;
                  rem_q    <= rem_d;
`ifdef CASE_9_SDIV_STATUS_EN
                  status_q <= {ovf_q, zero_q};
`endif
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign done = done_q;
   assign dout = dout_q;
   assign rem  = rem_q;
`ifdef CASE_9_SDIV_STATUS_EN
   assign status = status_q;
`endif

endmodule

// File: tb/tb_case_9_sdiv_7s_4s_7_seq.sv
// Self-checking bench for the sequential signed divider: directed corner
// cases plus randomized operands against an integer-arithmetic reference.
module tb_case_9_sdiv_7s_4s_7_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       ce;
   logic       start;
   logic [6:0] din0;
   logic [3:0] din1;
   logic       done;
   logic [6:0] dout;
   logic [3:0] rem;
`ifdef CASE_9_SDIV_STATUS_EN
   logic [1:0] status;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   case_9_sdiv_7s_4s_7_seq dut (
      .clk    (clk),
      .reset  (reset),
      .ce     (ce),
      .start  (start),
      .din0   (din0),
      .din1   (din1),
      .done   (done),
      .dout   (dout),
      .rem    (rem)
`ifdef CASE_9_SDIV_STATUS_EN
      ,
      .status (status)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: signed integer division truncating toward zero, remainder
   // takes the dividend's sign; x/0 gives -1 rem 0.
   task automatic ref_div(input logic [6:0] a, input logic [3:0] b,
                          output logic [6:0] q, output logic [3:0] r,
                          output logic [1:0] st);
      int sa;
      int sb;
      int iq;
      int ir;
      sa = $signed(a);
      sb = $signed(b);
      st = 2'b00;
      if (sb == 0) begin
         iq = -1;
         ir = 0;
         st = 2'b01;
      end else begin
         iq = sa / sb;
         ir = sa % sb;
         if (sa == -64 && sb == -1) st = 2'b10;
      end
      q = 7'(iq);
      r = 4'(ir);
   endtask

   // gap: ce-low cycles inserted mid-CALC; poke: re-issue start during CALC;
   // stretch: ce-low cycles during the done pulse.
   task automatic do_div(input string tag, input logic [6:0] a, input logic [3:0] b,
                         input int gap, input bit poke, input int stretch);
      logic [6:0] eq;
      logic [3:0] er;
      logic [1:0] est;
      int n;
      ref_div(a, b, eq, er, est);
      @(negedge clk);
      start = 1'b1;
      din0  = a;
      din1  = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      din0  = 7'($urandom);
      din1  = 4'($urandom);
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         ce    = (n >= 3 && n < 3 + gap) ? 1'b0 : 1'b1;
         start = poke && (n == 2);
         if (start) begin
            din0 = 7'($urandom);
            din1 = 4'($urandom);
         end
         @(posedge clk);
         #1;
         n++;
      end
      @(negedge clk);
      start = 1'b0;
      ce    = 1'b1;
      check_val({tag, "_lat"}, 32'(n), 32'(7 + gap));
      check_val({tag, "_dout"}, 32'(dout), 32'(eq));
      check_val({tag, "_rem"}, 32'(rem), 32'(er));
`ifdef CASE_9_SDIV_STATUS_EN
      check_val({tag, "_status"}, 32'(status), 32'(est));
`endif
      if (stretch > 0) begin
         ce = 1'b0;
         repeat (stretch) begin
            @(posedge clk);
            #1;
            check_val({tag, "_stretch_done"}, 32'(done), 32'(1));
         end
         @(negedge clk);
         ce = 1'b1;
      end
      @(posedge clk);
      #1;
      check_val({tag, "_done_low"}, 32'(done), 32'(0));
      check_val({tag, "_hold"}, 32'({dout, rem}), 32'({eq, er}));
   endtask

   initial begin
      reset = 1'b1;
      ce    = 1'b1;
      start = 1'b0;
      din0  = '0;
      din1  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_done", 32'(done), 32'(0));
      check_val("rst_dout", 32'(dout), 32'(0));
      check_val("rst_rem", 32'(rem), 32'(0));
      @(negedge clk);
      reset = 1'b0;

      do_div("basic", 7'd42, 4'd6, 0, 1'b0, 0);
      do_div("n43_6", 7'($signed(-43)), 4'd6, 0, 1'b0, 0);
      do_div("43_n5", 7'd43, 4'($signed(-5)), 0, 1'b0, 0);
      do_div("n43_n5", 7'($signed(-43)), 4'($signed(-5)), 0, 1'b0, 0);
      do_div("div0", 7'd17, 4'd0, 0, 1'b0, 0);
      do_div("ovf", 7'h40, 4'hF, 0, 1'b0, 0);
      do_div("n64_n8", 7'h40, 4'h8, 0, 1'b0, 0);
      do_div("poke", 7'd42, 4'd6, 0, 1'b1, 0);
      do_div("b2b", 7'd100 - 7'd50, 4'd7, 0, 1'b0, 0);
      do_div("ce_gap", 7'($signed(-43)), 4'd6, 3, 1'b0, 2);

      // Reset during CALC aborts and clears outputs.
      @(negedge clk);
      start = 1'b1;
      din0  = 7'd42;
      din1  = 4'd6;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_val("abort_done", 32'(done), 32'(0));
      check_val("abort_dout", 32'(dout), 32'(0));
      check_val("abort_rem", 32'(rem), 32'(0));
      @(negedge clk);
      reset = 1'b0;
      do_div("after_rst", 7'd42, 4'd6, 0, 1'b0, 0);

      for (int i = 0; i < 40; i++) begin
         do_div("rand", 7'($urandom), 4'($urandom),
                ($urandom_range(3, 0) == 0) ? int'($urandom_range(4, 1)) : 0,
                1'($urandom), int'($urandom_range(1, 0)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
